wb_quadrature_generator: RTL and testbench

Wishbone slave that synthesises a quadrature encoder signal pair (ch_A/ch_B) from register-programmed step period, step count and direction. It is the transmit end of the encoder interface decoded by wb_compatible_encoder: on the bench it feeds that decoder directly, and in the system it emulates an encoder for the servo driver. It sits on the shared Wishbone bus behind addressDecoder as a selectable slave.

---
 rtl/wb_quadrature_generator_pkg.sv | 42 ++++
 rtl/wb_quadrature_generator_stepper.sv | 27 ++
 rtl/wb_quadrature_generator.sv | 185 ++++++++++++++++++
 tb/tb_wb_quadrature_generator.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_quadrature_generator_pkg.sv
// Shared definitions for the Wishbone quadrature generator: register map,
// CTRL bit positions, FSM encoding and the gray-sequence step function.
package wb_quadrature_generator_pkg;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_PERIOD   = 2'd1;
  localparam logic [1:0] ADDR_STEPS    = 2'd2;
  localparam logic [1:0] ADDR_POSITION = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_DIR  = 1;
  localparam int CTRL_CONT = 2;
  localparam int CTRL_CLR  = 15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } qg_state_t;

  // {A,B} forward: 00 -> 10 -> 11 -> 01 -> 00; reverse walks the same ring backwards.
  function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic dir);
    logic [1:0] nxt;
    nxt = 2'b00;
    if (!dir) begin
      case (phase)
        2'b00:   nxt = 2'b10;
        2'b10:   nxt = 2'b11;
        2'b11:   nxt = 2'b01;
        default: nxt = 2'b00;
      endcase
    end else begin
      case (phase)
        2'b00:   nxt = 2'b01;
        2'b01:   nxt = 2'b11;
        2'b11:   nxt = 2'b10;
        default: nxt = 2'b00;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/wb_quadrature_generator_stepper.sv
// Holds the {A,B} phase and advances it one gray step per i_step pulse;
// o_up tells the position counter which way the next step moves.
module quad_phase_stepper
  import wb_quadrature_generator_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_step,
  input  logic       i_dir,
  output logic [1:0] o_phase,
  output logic       o_up
);

  logic [1:0] r_phase;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= 2'b00;
    end else if (i_step) begin
      r_phase <= next_phase(r_phase, i_dir);
    end
  end

  assign o_phase = r_phase;
  assign o_up    = ~i_dir;

endmodule

// File: rtl/wb_quadrature_generator.sv
// Wishbone slave that emits a programmable quadrature pair (ch_A/ch_B):
// PERIOD clocks per edge, STEPS edges (or continuous), signed POSITION count.
module wb_quadrature_generator
  import wb_quadrature_generator_pkg::*;
#(
  parameter int                            WISHBONE_DATAWIDTH    = 16,
  parameter int                            WISHBONE_ADDRESSWIDTH = 16,
  parameter logic [WISHBONE_DATAWIDTH-1:0] DEFAULT_PERIOD        = 16'd1875
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             CYC_I,
  input  logic                             STB_I,
  input  logic                             WE_I,
  input  logic [WISHBONE_ADDRESSWIDTH-1:0] ADR_I,
  input  logic [WISHBONE_DATAWIDTH-1:0]    DAT_I,
  output logic [WISHBONE_DATAWIDTH-1:0]    DAT_O,
  output logic                             ACK_O,
  output logic                             STALL_O,
  output logic                             ch_A,
  output logic                             ch_B,
  output logic                             busy,
  output logic                             done,
  output logic                             o_dbg_state
);

  localparam int DW = WISHBONE_DATAWIDTH;

  // Handshake: a request is STB_I & CYC_I & ~ACK_O. Writes commit on the request
  // edge; ACK_O and DAT_O are registered together and valid the following cycle.
  qg_state_t     r_state;
  logic          r_en;
  logic          r_dir;
  logic          r_cont;
  logic [DW-1:0] r_period;
  logic [DW-1:0] r_steps;
  logic [DW-1:0] r_position;
  logic [DW-1:0] r_timer;
  logic          r_ack;
  logic          r_done;
  logic [DW-1:0] r_dat_o;

  logic          w_req;
  logic          w_wr_ctrl;
  logic          w_wr_period;
  logic          w_wr_steps;
  logic          w_clr;
  logic          w_en_nxt;
  logic          w_cont_nxt;
  logic [DW-1:0] w_steps_nxt;
  logic [DW-1:0] w_period_eff;
  logic          w_terminal;
  logic          w_stop;
  logic          w_step;
  logic          w_last;
  logic          w_up;
  logic [1:0]    w_phase;
  logic [DW-1:0] w_ctrl_rd;
  logic [DW-1:0] w_rd_data;
  logic          w_unused_adr;

  assign w_req       = STB_I & CYC_I & ~r_ack;
  assign w_wr_ctrl   = w_req & WE_I & (ADR_I[1:0] == ADDR_CTRL);
  assign w_wr_period = w_req & WE_I & (ADR_I[1:0] == ADDR_PERIOD);
  assign w_wr_steps  = w_req & WE_I & (ADR_I[1:0] == ADDR_STEPS);
  assign w_clr       = w_wr_ctrl & DAT_I[CTRL_CLR];

  assign w_en_nxt    = w_wr_ctrl ? DAT_I[CTRL_EN]   : r_en;
  assign w_cont_nxt  = w_wr_ctrl ? DAT_I[CTRL_CONT] : r_cont;
  assign w_steps_nxt = w_wr_steps ? DAT_I : r_steps;

  // A stored PERIOD of 0 runs at the fastest rate, same as 1.
  assign w_period_eff = (r_period == '0) ? DW'(1) : r_period;
  assign w_terminal   = (r_timer >= (w_period_eff - DW'(1)));

  // Disabling suppresses a coincident step so the phase holds exactly where it was.
  assign w_stop = (r_state == ST_RUN) & w_wr_ctrl & ~DAT_I[CTRL_EN];
  assign w_step = (r_state == ST_RUN) & w_terminal & ~w_stop;
  assign w_last = w_step & ~r_cont & ~w_wr_steps & (r_steps == DW'(1));

  quad_phase_stepper u_stepper (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_step  (w_step),
    .i_dir   (r_dir),
    .o_phase (w_phase),
    .o_up    (w_up)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      case (r_state)
        ST_IDLE: begin
          if (w_en_nxt && (w_cont_nxt || (w_steps_nxt != '0))) begin
            r_state <= ST_RUN;
            r_timer <= '0;
          end
        end
        ST_RUN: begin
          if (w_stop || w_last || (!w_cont_nxt && (w_steps_nxt == '0))) begin
            r_state <= ST_IDLE;
          end
          if (w_step || w_wr_period) begin
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + DW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en       <= 1'b0;
      r_dir      <= 1'b0;
      r_cont     <= 1'b0;
      r_period   <= DEFAULT_PERIOD;
      r_steps    <= '0;
      r_position <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_en   <= DAT_I[CTRL_EN];
        r_dir  <= DAT_I[CTRL_DIR];
        r_cont <= DAT_I[CTRL_CONT];
      end
      if (w_wr_period) begin
        r_period <= DAT_I;
      end
      // A bus write to STEPS overrides the decrement of a coincident step.
      if (w_wr_steps) begin
        r_steps <= DAT_I;
      end else if (w_step && !r_cont && (r_steps != '0)) begin
        r_steps <= r_steps - DW'(1);
      end
      if (w_clr) begin
        r_position <= '0;
      end else if (w_step) begin
        r_position <= r_position + (w_up ? DW'(1) : {DW{1'b1}});
      end
    end
  end

  always_comb begin
    w_ctrl_rd            = '0;
    w_ctrl_rd[CTRL_EN]   = r_en;
    w_ctrl_rd[CTRL_DIR]  = r_dir;
    w_ctrl_rd[CTRL_CONT] = r_cont;
    w_rd_data            = '0;
    case (ADR_I[1:0])
      ADDR_CTRL:     w_rd_data = w_ctrl_rd;
      ADDR_PERIOD:   w_rd_data = r_period;
      ADDR_STEPS:    w_rd_data = r_steps;
      default:       w_rd_data = r_position;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack   <= 1'b0;
      r_dat_o <= '0;
    end else begin
      r_ack   <= w_req;
      r_dat_o <= (w_req && !WE_I) ? w_rd_data : '0;
    end
  end

  assign w_unused_adr = ^ADR_I[WISHBONE_ADDRESSWIDTH-1:2];

  assign DAT_O       = r_dat_o;
  assign ACK_O       = r_ack;
  assign STALL_O     = 1'b0;
  assign ch_A        = w_phase[1];
  assign ch_B        = w_phase[0];
  assign busy        = (r_state == ST_RUN);
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wb_quadrature_generator.sv
// Self-checking bench for wb_quadrature_generator: bus reads/writes, finite and
// continuous runs, position wrap, CLR coincidence, back-to-back ACKs, async reset.
module tb_wb_quadrature_generator;
  import wb_quadrature_generator_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        CYC_I = 1'b0;
  logic        STB_I = 1'b0;
  logic        WE_I = 1'b0;
  logic [15:0] ADR_I = '0;
  logic [15:0] DAT_I = '0;
  logic [15:0] DAT_O;
  logic        ACK_O;
  logic        STALL_O;
  logic        ch_A;
  logic        ch_B;
  logic        busy;
  logic        done;
  logic        o_dbg_state;

  wb_quadrature_generator dut (
    .clk         (clk),
    .reset       (reset),
    .CYC_I       (CYC_I),
    .STB_I       (STB_I),
    .WE_I        (WE_I),
    .ADR_I       (ADR_I),
    .DAT_I       (DAT_I),
    .DAT_O       (DAT_O),
    .ACK_O       (ACK_O),
    .STALL_O     (STALL_O),
    .ch_A        (ch_A),
    .ch_B        (ch_B),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;

  // reference model: phase index on the {A,B} ring and signed edge count
  int          m_idx = 0;
  logic [15:0] m_pos = '0;

  function automatic logic [1:0] gray(input int idx);
    case (idx & 3)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic wb_write(input logic [1:0] addr, input logic [15:0] data, output int req_edge);
    @(negedge clk);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = {14'b0, addr}; DAT_I = data;
    @(posedge clk);
    #1 req_edge = cyc;
    @(negedge clk);
    check_eq("ack_wr", ACK_O, 1);
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [15:0] data);
    int e;
    wb_write(addr, data, e);
  endtask

  task automatic wb_read(input logic [1:0] addr, output logic [15:0] data);
    @(negedge clk);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = {14'b0, addr};
    @(posedge clk);
    @(negedge clk);
    check_eq("ack_rd", ACK_O, 1);
    data = DAT_O;
    CYC_I = 1'b0; STB_I = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] addr, input logic [15:0] exp);
    logic [15:0] d;
    wb_read(addr, d);
    check_eq(tag, d, exp);
  endtask

  task automatic wait_done(input int target, input int budget);
    int i;
    i = 0;
    while (done_cnt < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check_eq("done_seen", done_cnt >= target, 1);
  endtask

  // Finite run: edge n appears n*max(P,1) clocks after the enabling write's edge.
  task automatic run_finite(input int p, input int s, input bit dir);
    int r, pe, n, k, total, d0;
    wr(ADDR_CTRL, 16'h0000);
    wr(ADDR_PERIOD, 16'(p));
    wr(ADDR_STEPS, 16'(s));
    pe = (p == 0) ? 1 : p;
    total = pe * s;
    d0 = done_cnt;
    wb_write(ADDR_CTRL, {13'b0, 1'b0, dir, 1'b1}, r);
    k = cyc - r;
    while (k <= total + 3) begin
      n = k / pe;
      if (n > s) n = s;
      check_eq("phase", {ch_A, ch_B}, gray(dir ? m_idx - n : m_idx + n));
      check_eq("busy", busy, k < total);
      check_eq("done", done, k == total);
      @(negedge clk);
      k = cyc - r;
    end
    check_eq("done_pulses", done_cnt - d0, 1);
    m_idx = dir ? m_idx - s : m_idx + s;
    m_pos = dir ? m_pos - 16'(s) : m_pos + 16'(s);
    read_check("position", ADDR_POSITION, m_pos);
    read_check("steps_end", ADDR_STEPS, 16'h0000);
  endtask

  initial begin
    int r, c, s, d0, k, acks;
    logic [15:0] v;

    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_phase", {ch_A, ch_B}, 2'b00);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ack", ACK_O, 0);
    check_eq("rst_dat", DAT_O, 16'h0000);
    check_eq("rst_stall", STALL_O, 0);
    reset = 1'b1;
    read_check("rst_ctrl", ADDR_CTRL, 16'h0000);
    read_check("rst_period", ADDR_PERIOD, 16'd1875);
    read_check("rst_steps", ADDR_STEPS, 16'h0000);
    read_check("rst_position", ADDR_POSITION, 16'h0000);

    // register readback, including write-only CLR reading as 0
    v = 16'($urandom_range(0, 65535));
    wr(ADDR_PERIOD, v);
    read_check("period_rb", ADDR_PERIOD, v);
    wr(ADDR_CTRL, 16'h8006);
    read_check("ctrl_rb", ADDR_CTRL, 16'h0006);
    wr(ADDR_POSITION, 16'h1234);
    read_check("pos_ro", ADDR_POSITION, 16'h0000);
    wr(ADDR_CTRL, 16'h0001);
    repeat (3) @(negedge clk);
    check_eq("idle_zero_steps", busy, 0);

    // directed forward and reverse runs
    run_finite(4, 8, 1'b0);
    wr(ADDR_CTRL, 16'h8000);
    m_pos = '0;
    run_finite(4, 8, 1'b1);

    // randomized finite runs
    for (int i = 0; i < 6; i++) begin
      run_finite($urandom_range(0, 4), $urandom_range(1, 10), 1'($urandom_range(0, 1)));
    end

    // continuous at PERIOD=0: one edge per clock until EN is cleared
    wr(ADDR_CTRL, 16'h0000);
    wr(ADDR_PERIOD, 16'h0000);
    d0 = done_cnt;
    wb_write(ADDR_CTRL, 16'h0005, r);
    repeat ($urandom_range(4, 12)) begin
      @(negedge clk);
      k = cyc - r;
      check_eq("cont_phase", {ch_A, ch_B}, gray(m_idx + k));
    end
    wb_write(ADDR_CTRL, 16'h0000, s);
    m_idx = m_idx + (s - r - 1);
    m_pos = m_pos + 16'(s - r - 1);
    check_eq("stop_phase", {ch_A, ch_B}, gray(m_idx));
    check_eq("stop_busy", busy, 0);
    repeat (5) @(negedge clk);
    check_eq("freeze_phase", {ch_A, ch_B}, gray(m_idx));
    check_eq("stop_no_done", done_cnt, d0);
    read_check("cont_position", ADDR_POSITION, m_pos);
    read_check("period_zero", ADDR_PERIOD, 16'h0000);

    // position wrap 7FFF -> 8000
    wr(ADDR_CTRL, 16'h8000);
    m_pos = '0;
    wr(ADDR_STEPS, 16'd32767);
    d0 = done_cnt;
    wr(ADDR_CTRL, 16'h0001);
    wait_done(d0 + 1, 40000);
    m_idx = m_idx + 32767;
    m_pos = m_pos + 16'd32767;
    read_check("pos_7fff", ADDR_POSITION, m_pos);
    wr(ADDR_CTRL, 16'h0000);
    wr(ADDR_STEPS, 16'd1);
    wr(ADDR_CTRL, 16'h0001);
    wait_done(d0 + 2, 100);
    m_idx = m_idx + 1;
    m_pos = m_pos + 16'd1;
    read_check("pos_8000", ADDR_POSITION, 16'h8000);
    check_eq("model_8000", m_pos, 16'h8000);

    // CLR coinciding with a step: position restarts from 0 at that edge
    wr(ADDR_CTRL, 16'h0000);
    wb_write(ADDR_CTRL, 16'h0005, r);
    repeat ($urandom_range(2, 6)) @(negedge clk);
    wb_write(ADDR_CTRL, 16'h8005, c);
    repeat ($urandom_range(2, 6)) @(negedge clk);
    wb_write(ADDR_CTRL, 16'h0000, s);
    m_idx = m_idx + (s - r - 1);
    m_pos = 16'(s - c - 1);
    read_check("clr_on_step", ADDR_POSITION, m_pos);
    check_eq("clr_phase", {ch_A, ch_B}, gray(m_idx));

    // held STB_I on a read: ACK on alternate cycles
    wr(ADDR_PERIOD, 16'd37);
    @(negedge clk);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = {14'b0, ADDR_PERIOD};
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("b2b_ack", ACK_O, (i % 2) == 0);
      if (ACK_O) begin
        acks++;
        check_eq("b2b_dat", DAT_O, 16'd37);
      end
    end
    CYC_I = 1'b0; STB_I = 1'b0;
    check_eq("b2b_count", acks, 3);

    // asynchronous reset in the middle of a run
    wr(ADDR_PERIOD, 16'd2);
    wb_write(ADDR_CTRL, 16'h0005, r);
    k = cyc - r;
    while (gray(m_idx + k / 2) == 2'b00 && k < 10) begin
      @(negedge clk);
      k = cyc - r;
    end
    check_eq("pre_rst_phase", {ch_A, ch_B}, gray(m_idx + k / 2));
    check_eq("pre_rst_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("async_phase", {ch_A, ch_B}, 2'b00);
    check_eq("async_busy", busy, 0);
    check_eq("async_state", o_dbg_state, 0);
    @(negedge clk);
    reset = 1'b1;
    m_idx = 0;
    m_pos = '0;
    read_check("post_rst_period", ADDR_PERIOD, 16'd1875);
    read_check("post_rst_ctrl", ADDR_CTRL, 16'h0000);
    run_finite(1, 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
